// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write channel (AW/W/B) between NUM_REQ requesters.
// Optional macro AXI_WR_ARB_PRIO0_EN: requester 0 overrides round-robin in IDLE.
module axi_wr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned MAX_OUT = 8,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ),
  localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        s_awvalid,
  output logic [NUM_REQ-1:0]        s_awready,
  input  logic [NUM_REQ*ADDR_W-1:0] s_awaddr,
  input  logic [NUM_REQ*ID_W-1:0]   s_awid,
  input  logic [NUM_REQ*8-1:0]      s_awlen,
  input  logic [NUM_REQ-1:0]        s_wvalid,
  output logic [NUM_REQ-1:0]        s_wready,
  input  logic [NUM_REQ*DATA_W-1:0] s_wdata,
  input  logic [NUM_REQ-1:0]        s_wlast,
  output logic [NUM_REQ-1:0]        s_bvalid,
  input  logic [NUM_REQ-1:0]        s_bready,
  output logic [ID_W-1:0]           s_bid,
  output logic [1:0]                s_bresp,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [ADDR_W-1:0]         m_awaddr,
  output logic [ID_W+IDX_W-1:0]     m_awid,
  output logic [7:0]                m_awlen,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  output logic [DATA_W-1:0]         m_wdata,
  output logic                      m_wlast,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  input  logic [ID_W+IDX_W-1:0]     m_bid,
  input  logic [1:0]                m_bresp,
  output logic [CNT_W-1:0]          outstanding
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IDX_W-1:0]        r_grant;
  logic [IDX_W-1:0]        r_rr_ptr;
  logic [ADDR_W-1:0]       r_awaddr;
  logic [ID_W+IDX_W-1:0]   r_awid;
  logic [7:0]              r_awlen;
  logic [CNT_W-1:0]        r_outstanding;

  logic [IDX_W-1:0]        w_pick;
  logic [IDX_W-1:0]        w_cand;
  logic                    w_found;
  logic                    w_grant_en;
  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_b_hs;
  logic [IDX_W-1:0]        w_bidx;

  logic [ADDR_W-1:0]       w_awaddr_a [NUM_REQ];
  logic [ID_W-1:0]         w_awid_a   [NUM_REQ];
  logic [7:0]              w_awlen_a  [NUM_REQ];
  logic [DATA_W-1:0]       w_wdata_a  [NUM_REQ];

`ifdef AXI_WR_ARB_PRIO0_EN
  logic                    w_prio_hit;
  logic                    r_prio_gnt;
`endif

  // Per-requester views of the packed upstream buses.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_awaddr_a[gi] = s_awaddr[gi*ADDR_W +: ADDR_W];
    assign w_awid_a[gi]   = s_awid[gi*ID_W +: ID_W];
    assign w_awlen_a[gi]  = s_awlen[gi*8 +: 8];
    assign w_wdata_a[gi]  = s_wdata[gi*DATA_W +: DATA_W];
  end

  // First requesting index at or after the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_cand = r_rr_ptr + IDX_W'(i);
      if (!w_found && s_awvalid[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
`ifdef AXI_WR_ARB_PRIO0_EN
    w_prio_hit = s_awvalid[0];
    if (s_awvalid[0]) begin
      w_found = 1'b1;
      w_pick  = '0;
    end
`endif
  end

  assign w_grant_en = (r_state == IDLE) && w_found && (r_outstanding < MAX_CNT);
  assign w_aw_hs    = m_awvalid && m_awready;
  assign w_w_hs     = m_wvalid && m_wready;
  assign w_b_hs     = m_bvalid && m_bready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant_en) w_state_nxt = ADDR;
      ADDR:    if (w_aw_hs) w_state_nxt = DATA;
      DATA:    if (w_w_hs && m_wlast) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant capture, AW field registers, round-robin pointer and outstanding count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_awaddr      <= '0;
      r_awid        <= '0;
      r_awlen       <= '0;
      r_outstanding <= '0;
`ifdef AXI_WR_ARB_PRIO0_EN
      r_prio_gnt    <= 1'b0;
`endif
    end else begin
      if (w_grant_en) begin
        r_grant  <= w_pick;
        r_awaddr <= w_awaddr_a[w_pick];
        r_awid   <= {w_pick, w_awid_a[w_pick]};
        r_awlen  <= w_awlen_a[w_pick];
`ifdef AXI_WR_ARB_PRIO0_EN
        r_prio_gnt <= w_prio_hit;
`endif
      end
      if (w_aw_hs) begin
`ifdef AXI_WR_ARB_PRIO0_EN
        if (!r_prio_gnt) r_rr_ptr <= r_grant + IDX_W'(1);
`else
        r_rr_ptr <= r_grant + IDX_W'(1);
`endif
      end
      case ({w_aw_hs, w_b_hs})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign m_awvalid   = (r_state == ADDR);
  assign m_awaddr    = r_awaddr;
  assign m_awid      = r_awid;
  assign m_awlen     = r_awlen;
  assign outstanding = r_outstanding;

  // AW ready and W pass-through for the granted requester only.
  always_comb begin
    s_awready = '0;
    s_wready  = '0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wlast   = 1'b0;
    if (r_state == ADDR) s_awready[r_grant] = m_awready;
    if (r_state == DATA) begin
      m_wvalid          = s_wvalid[r_grant];
      s_wready[r_grant] = m_wready;
      m_wdata           = w_wdata_a[r_grant];
      m_wlast           = s_wlast[r_grant];
    end
  end

  // B routing by the index bits prepended to AWID.
  assign w_bidx   = m_bid[ID_W+IDX_W-1:ID_W];
  assign s_bid    = m_bid[ID_W-1:0];
  assign s_bresp  = m_bresp;
  assign m_bready = s_bready[w_bidx];

  always_comb begin
    s_bvalid         = '0;
    s_bvalid[w_bidx] = m_bvalid;
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter (4 requesters, default round-robin build).
module tb_axi_wr_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   s_awvalid, s_awready;
  logic [127:0] s_awaddr;
  logic [15:0]  s_awid;
  logic [31:0]  s_awlen;
  logic [3:0]   s_wvalid, s_wready;
  logic [255:0] s_wdata;
  logic [3:0]   s_wlast;
  logic [3:0]   s_bvalid, s_bready;
  logic [3:0]   s_bid;
  logic [1:0]   s_bresp;
  logic         m_awvalid, m_awready;
  logic [31:0]  m_awaddr;
  logic [5:0]   m_awid;
  logic [7:0]   m_awlen;
  logic         m_wvalid, m_wready;
  logic [63:0]  m_wdata;
  logic         m_wlast;
  logic         m_bvalid, m_bready;
  logic [5:0]   m_bid;
  logic [1:0]   m_bresp;
  logic [3:0]   outstanding;

  logic         wr_base, tog, tog_en;
  int           total, bad;
  logic [63:0]  w_log [$];
  logic         wl_log [$];
  logic [5:0]   aw_log [$];

  assign m_wready = tog_en ? tog : wr_base;

  axi_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_awid(s_awid), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_awid(m_awid), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .outstanding(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    tog = ~tog;
  end

  // Records downstream handshakes one half-cycle before the capturing edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_awvalid && m_awready) aw_log.push_back(m_awid);
      if (m_wvalid && m_wready) begin
        w_log.push_back(m_wdata);
        wl_log.push_back(m_wlast);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    s_awvalid = '0; s_awaddr = '0; s_awid = '0; s_awlen = '0;
    s_wvalid = '0; s_wdata = '0; s_wlast = '0; s_bready = '0;
    m_awready = 1'b1; wr_base = 1'b1; tog_en = 1'b0;
    m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_aw(input int r, input logic [31:0] addr, input logic [3:0] id,
                       input logic [7:0] len);
    bit ok;
    ok = 1'b0;
    s_awaddr[r*32 +: 32] = addr;
    s_awid[r*4 +: 4]     = id;
    s_awlen[r*8 +: 8]    = len;
    s_awvalid[r]         = 1'b1;
    for (int c = 0; c < 64 && !ok; c++) begin
      @(negedge clk);
      if (s_awready[r]) ok = 1'b1;
      @(posedge clk); #1;
    end
    s_awvalid[r] = 1'b0;
    chk("aw_hs", 64'(ok), 64'd1);
  endtask

  task automatic do_w(input int r, input int n, input logic [63:0] base, input bit last);
    bit ok;
    for (int b = 0; b < n; b++) begin
      s_wdata[r*64 +: 64] = base + 64'(b);
      s_wlast[r]          = last && (b == n - 1);
      s_wvalid[r]         = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 64 && !ok; c++) begin
        @(negedge clk);
        if (s_wready[r]) ok = 1'b1;
        @(posedge clk); #1;
      end
      chk("w_hs", 64'(ok), 64'd1);
    end
    s_wvalid[r] = 1'b0;
    s_wlast[r]  = 1'b0;
  endtask

  task automatic do_b(input logic [5:0] bid);
    m_bvalid = 1'b1; m_bid = bid; m_bresp = 2'b00; s_bready = 4'hf;
    @(negedge clk);
    chk("b_ready", 64'(m_bready), 64'd1);
    @(posedge clk); #1;
    m_bvalid = 1'b0; s_bready = '0;
  endtask

  task automatic chk_burst(input string tag, input int mark, input int n, input logic [63:0] base);
    chk({tag, "_cnt"}, 64'(w_log.size() - mark), 64'(n));
    for (int k = 0; k < n && (mark + k) < w_log.size(); k++) begin
      chk({tag, "_data"}, w_log[mark+k], base + 64'(k));
      chk({tag, "_last"}, 64'(wl_log[mark+k]), 64'(k == n - 1));
    end
  endtask

  initial begin
    int mark, amark, guard;
    logic [3:0] acc4;
    logic       acc1;
    logic [5:0] exp_ids [5];
    total = 0; bad = 0; tog = 1'b0;
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    chk("rst_awvalid", 64'(m_awvalid), 64'd0);
    chk("rst_wvalid", 64'(m_wvalid), 64'd0);
    chk("rst_awready", 64'(s_awready), 64'd0);
    chk("rst_wready", 64'(s_wready), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_awaddr", 64'(m_awaddr), 64'd0);
    chk("rst_awid", 64'(m_awid), 64'd0);
    chk("rst_bvalid", 64'(s_bvalid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single burst from requester 1.
    s_awaddr[32 +: 32] = 32'h100; s_awid[4 +: 4] = 4'd2; s_awlen[8 +: 8] = 8'd3;
    s_awvalid[1] = 1'b1;
    @(negedge clk);
    chk("t1_no_comb_aw", 64'(m_awvalid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_awvalid", 64'(m_awvalid), 64'd1);
    chk("t1_awready", 64'(s_awready), 64'h2);
    chk("t1_awaddr", 64'(m_awaddr), 64'h100);
    chk("t1_awid", 64'(m_awid), 64'h12);
    chk("t1_awlen", 64'(m_awlen), 64'd3);
    @(posedge clk); #1;
    s_awvalid[1] = 1'b0;
    @(negedge clk);
    chk("t1_out1", 64'(outstanding), 64'd1);
    chk("t1_awready_off", 64'(s_awready), 64'd0);
    @(posedge clk); #1;
    mark = w_log.size();
    do_w(1, 4, 64'h1000, 1'b1);
    chk_burst("t1_w", mark, 4, 64'h1000);
    @(negedge clk);
    chk("t1_idle_aw", 64'(m_awvalid), 64'd0);
    chk("t1_idle_w", 64'(m_wvalid), 64'd0);
    @(posedge clk); #1;
    m_bvalid = 1'b1; m_bid = 6'h12; m_bresp = 2'b10; s_bready = '0;
    @(negedge clk);
    chk("t1_bvalid", 64'(s_bvalid), 64'h2);
    chk("t1_bid", 64'(s_bid), 64'd2);
    chk("t1_bresp", 64'(s_bresp), 64'd2);
    chk("t1_bready_lo", 64'(m_bready), 64'd0);
    @(posedge clk); #1;
    s_bready[1] = 1'b1;
    @(negedge clk);
    chk("t1_bready_hi", 64'(m_bready), 64'd1);
    @(posedge clk); #1;
    m_bvalid = 1'b0; s_bready = '0;
    @(negedge clk);
    chk("t1_out0", 64'(outstanding), 64'd0);
    @(posedge clk); #1;

    // Fairness: all requesters continuously requesting single-beat bursts.
    do_reset();
    mark = w_log.size(); amark = aw_log.size();
    for (int r = 0; r < 4; r++) begin
      s_awid[r*4 +: 4] = 4'(r + 8);
      s_wdata[r*64 +: 64] = 64'(r);
    end
    s_awvalid = 4'hf; s_wvalid = 4'hf; s_wlast = 4'hf;
    guard = 0;
    while ((w_log.size() - mark) < 5 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    s_awvalid = '0; s_wvalid = '0; s_wlast = '0;
    chk("t2_beats", 64'(w_log.size() - mark), 64'd5);
    exp_ids = '{6'h08, 6'h19, 6'h2a, 6'h3b, 6'h08};
    for (int k = 0; k < 5 && (amark + k) < aw_log.size(); k++)
      chk("t2_order", 64'(aw_log[amark+k]), 64'(exp_ids[k]));
    @(negedge clk);
    chk("t2_out5", 64'(outstanding), 64'd5);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) do_b(exp_ids[k]);
    @(negedge clk);
    chk("t2_out0", 64'(outstanding), 64'd0);
    @(posedge clk); #1;

    // Backpressure: AW stalled 6 cycles, then W ready toggling.
    m_awready = 1'b0;
    s_awaddr[96 +: 32] = 32'h300; s_awid[12 +: 4] = 4'd5; s_awlen[24 +: 8] = 8'd3;
    s_awvalid[3] = 1'b1;
    acc4 = '0;
    repeat (6) begin
      @(negedge clk);
      acc4 |= s_awready;
      @(posedge clk); #1;
    end
    chk("t3_no_awready", 64'(acc4), 64'd0);
    @(negedge clk);
    chk("t3_awvalid_held", 64'(m_awvalid), 64'd1);
    chk("t3_awid", 64'(m_awid), 64'h35);
    @(posedge clk); #1;
    m_awready = 1'b1;
    @(negedge clk);
    chk("t3_awready", 64'(s_awready), 64'h8);
    @(posedge clk); #1;
    s_awvalid[3] = 1'b0;
    tog_en = 1'b1;
    mark = w_log.size();
    do_w(3, 4, 64'h3000, 1'b1);
    tog_en = 1'b0;
    chk_burst("t3_w", mark, 4, 64'h3000);
    do_b(6'h35);

    // Outstanding limit: 8 bursts without B, 9th stalls until one B returns.
    for (int k = 0; k < 8; k++) begin
      do_aw(0, 32'h400 + 32'(k * 16), 4'd1, 8'd0);
      do_w(0, 1, 64'(k), 1'b1);
    end
    @(negedge clk);
    chk("t4_out8", 64'(outstanding), 64'd8);
    @(posedge clk); #1;
    s_awaddr[64 +: 32] = 32'h900; s_awid[8 +: 4] = 4'd3; s_awlen[16 +: 8] = 8'd0;
    s_awvalid[2] = 1'b1;
    acc1 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      acc1 |= m_awvalid;
      @(posedge clk); #1;
    end
    chk("t4_stall", 64'(acc1), 64'd0);
    m_bvalid = 1'b1; m_bid = 6'h01; s_bready = 4'hf;
    @(negedge clk);
    chk("t4_stall_b", 64'(m_awvalid), 64'd0);
    @(posedge clk); #1;
    m_bvalid = 1'b0; s_bready = '0;
    @(negedge clk);
    chk("t4_out7", 64'(outstanding), 64'd7);
    chk("t4_decide", 64'(m_awvalid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_granted", 64'(m_awvalid), 64'd1);
    chk("t4_awid", 64'(m_awid), 64'h23);
    @(posedge clk); #1;
    s_awvalid[2] = 1'b0;
    @(negedge clk);
    chk("t4_out8b", 64'(outstanding), 64'd8);
    @(posedge clk); #1;
    do_w(2, 1, 64'h99, 1'b1);

    // Simultaneous AW and B handshake at outstanding=3.
    for (int k = 0; k < 5; k++) do_b(6'h01);
    @(negedge clk);
    chk("t5_out3", 64'(outstanding), 64'd3);
    @(posedge clk); #1;
    m_awready = 1'b0;
    s_awid[4 +: 4] = 4'd4; s_awlen[8 +: 8] = 8'd0; s_awvalid[1] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_addr", 64'(m_awvalid), 64'd1);
    @(posedge clk); #1;
    m_awready = 1'b1; m_bvalid = 1'b1; m_bid = 6'h01; s_bready = 4'hf;
    @(negedge clk);
    chk("t5_awready", 64'(s_awready), 64'h2);
    chk("t5_bready", 64'(m_bready), 64'd1);
    @(posedge clk); #1;
    m_bvalid = 1'b0; s_bready = '0; s_awvalid[1] = 1'b0;
    @(negedge clk);
    chk("t5_out_same", 64'(outstanding), 64'd3);
    @(posedge clk); #1;
    do_w(1, 1, 64'h55, 1'b1);

    // Asynchronous reset during beat 2 of 4, then a clean burst from requester 2.
    do_reset();
    do_aw(2, 32'h200, 4'd7, 8'd3);
    do_w(2, 1, 64'h2000, 1'b0);
    s_wdata[128 +: 64] = 64'h2001; s_wvalid[2] = 1'b1;
    @(negedge clk);
    chk("t6_beat2", 64'(m_wvalid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_wvalid", 64'(m_wvalid), 64'd0);
    chk("t6_rst_awvalid", 64'(m_awvalid), 64'd0);
    chk("t6_rst_out", 64'(outstanding), 64'd0);
    chk("t6_rst_wready", 64'(s_wready), 64'd0);
    s_wvalid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_aw(2, 32'h200, 4'd7, 8'd3);
    mark = w_log.size();
    do_w(2, 4, 64'h2100, 1'b1);
    chk_burst("t6_w", mark, 4, 64'h2100);
    @(negedge clk);
    chk("t6_out1", 64'(outstanding), 64'd1);
    @(posedge clk); #1;
    m_bvalid = 1'b1; m_bid = 6'h27; s_bready = 4'h4;
    @(negedge clk);
    chk("t6_bvalid", 64'(s_bvalid), 64'h4);
    chk("t6_bid", 64'(s_bid), 64'd7);
    @(posedge clk); #1;
    m_bvalid = 1'b0; s_bready = '0;
    @(negedge clk);
    chk("t6_out0", 64'(outstanding), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
